// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode skid FIFO: captures each (pc, instr) pair from the synchronous
// instruction memory, presents it to decode, and throttles / boots the fetch stage.
module fetch_decode_buffer #(
    parameter int DEPTH = 3,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            async_rst,
    input  logic            jmp,
    input  logic [29:0]     fetch_pc,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            fetch_en,
    output logic            fetch_rst,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [29:0]     id_pc,
    output logic [XLEN-1:0] id_instr
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C  = CW1'(DEPTH);

    logic [CW-1:0]   count;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            in_flight;
    logic [29:0]     pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [CW:0]     occupancy;
    logic            push;
    logic            pop;
    logic            flush;

    // Throttle counts the pair already in flight so a stall never drops read data.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, in_flight};
        fetch_en  = !fetch_rst && (jmp || (occupancy < DEPTH_C));
    end

    assign id_valid = (count != '0);
    assign push     = in_flight && !jmp;
    assign pop      = id_valid && id_ready && !jmp;
    assign flush    = jmp && !fetch_rst;
    assign id_pc    = pc_mem[head];
    assign id_instr = instr_mem[head];

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            fetch_rst <= 1'b1;
            in_flight <= 1'b0;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            fetch_rst <= 1'b0;
            in_flight <= fetch_en && !fetch_rst;
            if (flush) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (push) begin
                    pc_mem[tail]    <= fetch_pc;
                    instr_mem[tail] <= imem_rdata;
                    tail            <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
                end
                if (pop) begin
                    head <= (head == LAST_PTR) ? '0 : head + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end
endmodule
